// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM in the low address half, plus an MMIO block
// in the upper half (cycle counter, GPO register, 4-entry transmit FIFO).
module dmem_mmio_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] gpo,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CNT  = 2'd0,
        REG_GPO  = 2'd1,
        REG_TXD  = 2'd2,
        REG_STAT = 2'd3
    } mmio_reg_e;

    logic [31:0]           ram_q  [2**DEPTH_LOG2];
    logic [31:0]           fifo_q [FIFO_DEPTH];
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           gpo_q, gpo_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [2:0]            count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0] ram_idx;
    mmio_reg_e             sel;
    logic                  is_mmio, full, empty, pop, push_req, push, drop;
    logic                  unused_addr;

    assign ram_idx     = addr[DEPTH_LOG2+1:2];
    assign sel         = mmio_reg_e'(addr[3:2]);
    assign is_mmio     = addr[11];
    assign unused_addr = ^{addr[31:12], addr[10:DEPTH_LOG2+2], addr[1:0]};

    always_comb begin
        empty    = (count_q == 3'd0);
        full     = (count_q == 3'(FIFO_DEPTH));
        pop      = !empty && tx_ready;
        push_req = we && is_mmio && (sel == REG_TXD);
        // Fullness is judged after this cycle's pop, so push+pop on a full FIFO both succeed.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        cnt_d  = (we && is_mmio && sel == REG_CNT) ? wd : cnt_q + 32'd1;
        gpo_d  = (we && is_mmio && sel == REG_GPO) ? wd : gpo_q;
        rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        count_d = count_q + 3'(push) - 3'(pop);

        ovf_d = ovf_q;
        if (we && is_mmio && sel == REG_STAT && wd[5]) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            gpo_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gpo_q   <= gpo_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage arrays are not reset; pointer/count reset makes stale FIFO entries unreachable.
    always_ff @(posedge clk) begin
        if (we && !is_mmio) ram_q[ram_idx] <= wd;
        if (push) fifo_q[wptr_q] <= wd;
    end

    always_comb begin
        rd = '0;
        if (!is_mmio) begin
            rd = ram_q[ram_idx];
        end else begin
            unique case (sel)
                REG_CNT:  rd = cnt_q;
                REG_GPO:  rd = gpo_q;
                REG_TXD:  rd = empty ? '0 : fifo_q[rptr_q];
                REG_STAT: rd = {26'd0, ovf_q, empty, full, count_q};
                default:  rd = '0;
            endcase
        end
    end

    assign gpo      = gpo_q;
    assign tx_valid = !empty;
    assign tx_data  = empty ? '0 : fifo_q[rptr_q];
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: hand-derived vector table, reset sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_dmem_mmio_responder;
    logic        clk = 1'b0;
    logic        rst, we, tx_ready;
    logic [31:0] addr, wd;
    logic [31:0] rd, gpo, tx_data;
    logic        tx_valid;

    dmem_mmio_responder #(.DEPTH_LOG2(6), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
        .gpo(gpo), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wd;
        bit        rdy;
        bit        chk_rd;
        bit [31:0] exp_rd;
        bit        exp_v;
        bit [31:0] exp_d;
        bit [31:0] exp_g;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] m_ram [64];
    bit [31:0] m_cnt, m_gpo;
    bit        m_ovf;
    bit [31:0] m_q [$];

    function automatic vec_t v(bit r, bit w, bit [31:0] a, bit [31:0] d, bit rdy,
                               bit c, bit [31:0] erd, bit ev, bit [31:0] ed, bit [31:0] eg);
        vec_t t;
        t.rst = r; t.we = w; t.addr = a; t.wd = d; t.rdy = rdy;
        t.chk_rd = c; t.exp_rd = erd; t.exp_v = ev; t.exp_d = ed; t.exp_g = eg;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit [31:0] m_rd(bit [31:0] a);
        int sz = m_q.size();
        if (!a[11]) return m_ram[a[7:2]];
        case (a[3:2])
            2'd0: return m_cnt;
            2'd1: return m_gpo;
            2'd2: return (sz != 0) ? m_q[0] : 32'd0;
            default: return 32'(sz) | ((sz == 4) ? 32'h8 : 32'h0) |
                            ((sz == 0) ? 32'h10 : 32'h0) | (m_ovf ? 32'h20 : 32'h0);
        endcase
    endfunction

    task automatic model_edge(vec_t t);
        bit pop;
        if (t.rst) begin
            m_cnt = 0; m_gpo = 0; m_ovf = 0; m_q.delete();
            return;
        end
        pop = (m_q.size() != 0) && t.rdy;
        if (t.we && t.addr[11] && t.addr[3:2] == 2'd0) m_cnt = t.wd;
        else m_cnt = m_cnt + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (t.we && !t.addr[11]) m_ram[t.addr[7:2]] = t.wd;
        if (t.we && t.addr[11]) begin
            case (t.addr[3:2])
                2'd1: m_gpo = t.wd;
                2'd2: if (m_q.size() < 4) m_q.push_back(t.wd); else m_ovf = 1'b1;
                2'd3: if (t.wd[5]) m_ovf = 1'b0;
                default: ;
            endcase
        end
    endtask

    // mode 0: no check, 1: check against the vector's constants, 2: check against model
    task automatic step(vec_t t, int mode, string nm);
        rst = t.rst; we = t.we; addr = t.addr; wd = t.wd; tx_ready = t.rdy;
        #1;
        if (mode == 1) begin
            if (t.chk_rd) chk({nm, ".rd"}, rd, t.exp_rd);
            chk({nm, ".tx_valid"}, 32'(tx_valid), 32'(t.exp_v));
            chk({nm, ".tx_data"}, tx_data, t.exp_d);
            chk({nm, ".gpo"}, gpo, t.exp_g);
        end else if (mode == 2) begin
            chk({nm, ".rd"}, rd, m_rd(t.addr));
            chk({nm, ".tx_valid"}, 32'(tx_valid), 32'(m_q.size() != 0));
            chk({nm, ".tx_data"}, tx_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
            chk({nm, ".gpo"}, gpo, m_gpo);
        end
        @(posedge clk);
        model_edge(t);
        @(negedge clk);
    endtask

    vec_t tab [$];
    vec_t rs  [$];

    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; wd = '0; tx_ready = 1'b0;
        @(negedge clk);
        step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, "rst0");
        for (int i = 0; i < 64; i++)
            step(v(0, 1, 32'(i * 4), 32'h1000_0000 + 32'(i), 0, 0, 0, 0, 0, 0), 0, "init");
        step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, "rst1");

        // RAM and counter
        tab.push_back(v(0, 0, 'h800, 0, 0, 1, 0, 0, 0, 0));
        tab.push_back(v(0, 1, 'h10, 'hDEADBEEF, 0, 1, 'h10000004, 0, 0, 0));
        tab.push_back(v(0, 0, 'h10, 0, 0, 1, 'hDEADBEEF, 0, 0, 0));
        tab.push_back(v(0, 0, 'h1010, 0, 0, 1, 'hDEADBEEF, 0, 0, 0));
        tab.push_back(v(0, 1, 'h10, 1, 0, 1, 'hDEADBEEF, 0, 0, 0));
        tab.push_back(v(0, 0, 'h10, 0, 0, 1, 1, 0, 0, 0));
        tab.push_back(v(0, 1, 'h800, 'hFFFFFFFE, 0, 1, 6, 0, 0, 0));
        tab.push_back(v(0, 0, 'h800, 0, 0, 1, 'hFFFFFFFE, 0, 0, 0));
        tab.push_back(v(0, 0, 'h800, 0, 0, 1, 'hFFFFFFFF, 0, 0, 0));
        tab.push_back(v(0, 0, 'h800, 0, 0, 1, 0, 0, 0, 0));
        // FIFO fill, overflow, drain, clear
        tab.push_back(v(0, 1, 'h808, 1, 0, 1, 0, 0, 0, 0));
        tab.push_back(v(0, 1, 'h808, 2, 0, 1, 1, 1, 1, 0));
        tab.push_back(v(0, 1, 'h808, 3, 0, 1, 1, 1, 1, 0));
        tab.push_back(v(0, 1, 'h808, 4, 0, 1, 1, 1, 1, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h0C, 1, 1, 0));
        tab.push_back(v(0, 1, 'h808, 5, 0, 1, 1, 1, 1, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h2C, 1, 1, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h2C, 1, 1, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h23, 1, 2, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h22, 1, 3, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h21, 1, 4, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h30, 0, 0, 0));
        tab.push_back(v(0, 1, 'h80C, 'h20, 0, 1, 'h30, 0, 0, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h10, 0, 0, 0));
        // Simultaneous push/pop while full
        tab.push_back(v(0, 1, 'h808, 10, 0, 1, 0, 0, 0, 0));
        tab.push_back(v(0, 1, 'h808, 11, 0, 1, 10, 1, 10, 0));
        tab.push_back(v(0, 1, 'h808, 12, 0, 1, 10, 1, 10, 0));
        tab.push_back(v(0, 1, 'h808, 13, 0, 1, 10, 1, 10, 0));
        tab.push_back(v(0, 1, 'h808, 14, 1, 1, 10, 1, 10, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h0C, 1, 11, 0));
        tab.push_back(v(0, 0, 'h808, 0, 1, 1, 11, 1, 11, 0));
        tab.push_back(v(0, 0, 'h808, 0, 1, 1, 12, 1, 12, 0));
        tab.push_back(v(0, 0, 'h808, 0, 1, 1, 13, 1, 13, 0));
        tab.push_back(v(0, 0, 'h808, 0, 1, 1, 14, 1, 14, 0));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h10, 0, 0, 0));
        // Backpressure
        tab.push_back(v(0, 1, 'h808, 'hA, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tab.push_back(v(0, 0, 'h808, 0, 0, 1, 'hA, 1, 'hA, 0));
        tab.push_back(v(0, 0, 'h808, 0, 1, 1, 'hA, 1, 'hA, 0));
        tab.push_back(v(0, 0, 'h808, 0, 0, 1, 0, 0, 0, 0));
        // GPO, then push into empty FIFO with ready high (no bypass)
        tab.push_back(v(0, 1, 'h804, 'h55, 0, 1, 0, 0, 0, 0));
        tab.push_back(v(0, 0, 'h804, 0, 0, 1, 'h55, 0, 0, 'h55));
        tab.push_back(v(0, 1, 'h808, 'h77, 1, 1, 0, 0, 0, 'h55));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h01, 1, 'h77, 'h55));
        tab.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h01, 1, 'h77, 'h55));
        tab.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h10, 0, 0, 'h55));
        foreach (tab[i]) step(tab[i], 1, $sformatf("vec%0d", i));

        // Reset in the middle of activity
        rs.push_back(v(0, 1, 'h40, 'hCAFEF00D, 0, 0, 0, 0, 0, 'h55));
        rs.push_back(v(0, 1, 'h808, 1, 0, 0, 0, 0, 0, 'h55));
        for (int i = 2; i <= 5; i++)
            rs.push_back(v(0, 1, 'h808, 32'(i), 0, 0, 0, 1, 1, 'h55));
        rs.push_back(v(0, 0, 'h80C, 0, 1, 1, 'h2C, 1, 1, 'h55));
        rs.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h23, 1, 2, 'h55));
        rs.push_back(v(0, 1, 'h800, 100, 0, 0, 0, 1, 2, 'h55));
        rs.push_back(v(1, 0, 'h800, 0, 1, 1, 100, 1, 2, 'h55));
        rs.push_back(v(0, 0, 'h800, 0, 0, 1, 0, 0, 0, 0));
        rs.push_back(v(0, 0, 'h800, 0, 0, 1, 1, 0, 0, 0));
        rs.push_back(v(0, 0, 'h80C, 0, 0, 1, 'h10, 0, 0, 0));
        rs.push_back(v(0, 0, 'h40, 0, 0, 1, 'hCAFEF00D, 0, 0, 0));
        foreach (rs[i]) step(rs[i], 1, $sformatf("rstseq%0d", i));

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            vec_t t;
            t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            t.addr = $urandom;
            t.addr[11] = ($urandom_range(0, 1) == 1);
            t.wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            t.we  = ($urandom_range(0, 1) == 1);
            t.rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) begin
                t.rst = 1'b1;
                t.we  = 1'b0;
            end
            step(t, 2, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
